// File: rtl/exe_unit_pipe.sv
// ---------------------------------------------------------------------------
// exe_unit_pipe -- two-stage sign-magnitude execution unit
//
// Operands are BITS wide in sign-magnitude form (MSB = sign, BITS-1 magnitude
// bits). Stage 1 captures operands and opcode on a valid/ready handshake.
// Stage 2 holds the computed result until the downstream consumer takes it.
// With no stall the latency is 2 cycles and the throughput is 1 op/cycle.
//
// Opcodes: 00 SUB (A-B), 01 CMP (signed max), 10 SHL (A << |B|),
//          11 BIT (toggle bit B of A).
// Status:  [0] OVF, [1] ERR, [2] EVEN (even popcount of o_out),
//          [3] SINGLE (exactly one set bit in o_out).
//
// Ports:
//   i_clk        in   1     rising-edge clock
//   i_rst        in   1     asynchronous active-high reset
//   in_a, in_b   in   BITS  operands
//   i_op         in   2     opcode
//   i_valid      in   1     operands/opcode valid
//   o_ready      out  1     unit accepts operands this cycle
//   o_out        out  BITS  result
//   o_status     out  4     result flags
//   o_valid      out  1     o_out/o_status valid
//   i_ready      in   1     downstream accepts result
//   i_sticky_clr in   1     (EXE_UNIT_STICKY_EN only) clear sticky flags
//   o_sticky     out  4     (EXE_UNIT_STICKY_EN only) OR of delivered status
//
// Build option: define EXE_UNIT_STICKY_EN to add the sticky status register.
// ---------------------------------------------------------------------------
module exe_unit_pipe #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic [1:0]      i_op,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [BITS-1:0] o_out,
    output logic [3:0]      o_status,
    output logic            o_valid,
`ifdef EXE_UNIT_STICKY_EN
    input  logic            i_sticky_clr,
    output logic [3:0]      o_sticky,
`endif
    input  logic            i_ready
);

    localparam int MAGW = BITS - 1;
    localparam logic [BITS-1:0] ONE    = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0] BITS_U = BITS[BITS-1:0];

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_CMP = 2'b01,
        OP_SHL = 2'b10,
        OP_BIT = 2'b11
    } op_e;

    // Stage 1: captured operands
    logic            s1_valid_q, s1_valid_d;
    logic [BITS-1:0] s1_a_q, s1_a_d;
    logic [BITS-1:0] s1_b_q, s1_b_d;
    op_e             s1_op_q, s1_op_d;

    // Stage 2: registered result
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_q, out_d;
    logic [3:0]      status_q, status_d;

    logic accept;
    logic advance;

    // Stage 2 can take a new result when it is empty or being drained now.
    assign advance = ~out_valid_q | i_ready;
    assign o_ready = ~s1_valid_q | advance;
    assign accept  = i_valid & o_ready;

    // ---------------- datapath between S1 and S2 ----------------
    logic                   a_sgn, b_sgn;
    logic [MAGW-1:0]        a_mag, b_mag;
    logic signed [BITS:0]   a_val, b_val, diff;
    logic [BITS:0]          diff_abs;
    logic [MAGW-1:0]        shl_mag;
    logic [BITS-1:0]        res_val;
    logic [3:0]             res_status;
    logic                   ovf, err, even, single;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        ovf     = 1'b0;
        err     = 1'b0;
        res_val = '0;

        a_sgn = s1_a_q[BITS-1];
        b_sgn = s1_b_q[BITS-1];
        a_mag = s1_a_q[MAGW-1:0];
        b_mag = s1_b_q[MAGW-1:0];

        // One extra bit of headroom so A-B cannot overflow the signed range.
        a_val    = a_sgn ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
        b_val    = b_sgn ? -$signed({2'b00, b_mag}) : $signed({2'b00, b_mag});
        diff     = a_val - b_val;
        diff_abs = diff[BITS] ? $unsigned(-diff) : $unsigned(diff);

        shl_mag = a_mag << b_mag;

        unique case (s1_op_q)
            OP_SUB: begin
                // Magnitude wraps mod 2^(BITS-1); the sign of the true
                // difference is kept, so -128 on 8 bits becomes 0x80.
                res_val = {diff[BITS], diff_abs[MAGW-1:0]};
                ovf     = |diff_abs[BITS:MAGW];
            end
            OP_CMP: begin
                res_val = (a_val >= b_val) ? s1_a_q : s1_b_q;
                // A zero winner is always reported as +0.
                if (res_val[MAGW-1:0] == '0) begin
                    res_val = '0;
                end
            end
            OP_SHL: begin
                if (b_sgn) begin
                    err = 1'b1;
                end else begin
                    res_val = {a_sgn, shl_mag};
                    // Shifting back recovers A only if no set bit fell off.
                    ovf     = (shl_mag >> b_mag) != a_mag;
                end
            end
            OP_BIT: begin
                if (s1_b_q >= BITS_U) begin
                    err = 1'b1;
                end else begin
                    res_val = s1_a_q ^ (ONE << s1_b_q);
                end
            end
        endcase

        if (err) begin
            res_val = '0;
            ovf     = 1'b0;
        end

        even   = ~^res_val;
        single = (res_val != '0) && ((res_val & (res_val - ONE)) == '0);

        res_status = err ? 4'b0010 : {single, even, 1'b0, ovf};
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        status_d    = status_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = op_e'(i_op);
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        // Result data only changes when a new operation moves in, so an
        // empty stage 2 still shows the last delivered value.
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d    = res_val;
                status_d = res_status;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: operand registers are reset along with the valid flags so
            // the datapath never evaluates X after reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_SUB;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            status_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            status_q    <= status_d;
        end
    end

    assign o_valid  = out_valid_q;
    assign o_out    = out_q;
    assign o_status = status_q;

`ifdef EXE_UNIT_STICKY_EN
    logic [3:0] sticky_q, sticky_d;

    // Clear has priority over a flag arriving in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (i_sticky_clr) begin
            sticky_d = '0;
        end else if (out_valid_q & i_ready) begin
            sticky_d = sticky_q | status_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_sticky = sticky_q;
`else
    // Default build: no sticky status register.
`endif

endmodule

// File: tb/tb_exe_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_exe_unit_pipe -- self-checking bench for exe_unit_pipe (BITS = 8)
//
// A behavioural model computes each operation's result with integer
// arithmetic; a queue of accepted operations is compared against the DUT on
// every negative clock edge. Directed vectors with hand-computed literals pin
// both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_exe_unit_pipe;

    localparam int BITS = 8;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [BITS-1:0] in_a = '0;
    logic [BITS-1:0] in_b = '0;
    logic [1:0]      i_op = '0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [BITS-1:0] o_out;
    logic [3:0]      o_status;
    logic            o_valid;
    logic            i_ready = 1'b1;
`ifdef EXE_UNIT_STICKY_EN
    logic            i_sticky_clr = 1'b0;
    logic [3:0]      o_sticky;
`endif

    exe_unit_pipe #(.BITS(BITS)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .in_a     (in_a),
        .in_b     (in_b),
        .i_op     (i_op),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_out    (o_out),
        .o_status (o_status),
        .o_valid  (o_valid),
`ifdef EXE_UNIT_STICKY_EN
        .i_sticky_clr (i_sticky_clr),
        .o_sticky     (o_sticky),
`endif
        .i_ready  (i_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: returns {status, out}.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        int ma, mb, va, vb, d, mag, cnt;
        logic ovf, err;
        logic [7:0] r;
        ma  = int'(a[6:0]);
        mb  = int'(b[6:0]);
        va  = a[7] ? -ma : ma;
        vb  = b[7] ? -mb : mb;
        ovf = 1'b0;
        err = 1'b0;
        r   = 8'h00;
        case (op)
            2'd0: begin
                d   = va - vb;
                mag = (d < 0) ? -d : d;
                ovf = (mag > 127);
                mag = mag % 128;
                r   = {(d < 0), 7'(mag)};
            end
            2'd1: begin
                r = (va >= vb) ? a : b;
                if (r[6:0] == 7'd0) r = 8'h00;
            end
            2'd2: begin
                if (b[7]) begin
                    err = 1'b1;
                end else begin
                    mag = ma;
                    for (int i = 0; i < mb; i++) begin
                        if (mag >= 64) ovf = 1'b1;
                        mag = (mag * 2) % 128;
                    end
                    r = {a[7], 7'(mag)};
                end
            end
            default: begin
                if (int'(b) >= BITS) err = 1'b1;
                else r = a ^ (8'd1 << b);
            end
        endcase
        if (err) return {4'b0010, 8'h00};
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(r[i]);
        return {(cnt == 1), (cnt % 2 == 0), 1'b0, ovf, r};
    endfunction

    typedef struct {
        logic [7:0] out;
        logic [3:0] status;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    logic       exp_valid;
    logic [11:0] m_res;

    // Compare process: the pipeline holds at most two operations, the oldest
    // one is visible two cycles after acceptance and stays until taken.
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst) begin
            check("o_ready", o_ready, (q.size() < 2) || i_ready);
            exp_valid = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            check("o_valid", o_valid, exp_valid);
            if (o_valid && q.size() > 0) begin
                check("o_out", o_out, q[0].out);
                check("o_status", o_status, q[0].status);
                if (i_ready) void'(q.pop_front());
            end
            if (i_valid && o_ready) begin
                m_res = model(in_a, in_b, i_op);
                q.push_back('{out: m_res[7:0], status: m_res[11:8], cyc: cyc});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int k;
        @(posedge i_clk);
        #1;
        in_a    = a;
        in_b    = b;
        i_op    = op;
        i_valid = 1'b1;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_ready && k < 20);
        check("send_accept", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] op, input logic [7:0] eo, input logic [3:0] es);
        int k;
        bit got;
        check({name, "_model"}, model(a, b, op), {es, eo});
        send(a, b, op);
        got = 1'b0;
        k   = 0;
        while (!got && k < 10) begin
            @(negedge i_clk);
            k++;
            if (o_valid) got = 1'b1;
        end
        check({name, "_latency"}, k, 2);
        check({name, "_out"}, o_out, eo);
        check({name, "_status"}, o_status, es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_out", o_out, 8'h00);
        check("rst_status", o_status, 4'b0000);
`ifdef EXE_UNIT_STICKY_EN
        check("rst_sticky", o_sticky, 4'b0000);
`endif
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Directed vectors
        directed("sub_ovf",  8'hFF, 8'h01, 2'd0, 8'h80, 4'b1001);
        directed("sub",      8'h5B, 8'h29, 2'd0, 8'h32, 4'b0000);
        directed("cmp",      8'hB2, 8'h04, 2'd1, 8'h04, 4'b1000);
        directed("shl_ovf",  8'h06, 8'h05, 2'd2, 8'h40, 4'b1001);
        directed("shl_err",  8'hC1, 8'h81, 2'd2, 8'h00, 4'b0010);
        directed("bit_err",  8'h00, 8'h08, 2'd3, 8'h00, 4'b0010);
        directed("bit",      8'h66, 8'h03, 2'd3, 8'h6E, 4'b0000);
        directed("sub_zero", 8'h05, 8'h05, 2'd0, 8'h00, 4'b0100);
        directed("cmp_zero", 8'h80, 8'h00, 2'd1, 8'h00, 4'b0100);
        directed("cmp_neg",  8'h85, 8'h83, 2'd1, 8'h83, 4'b0000);
        directed("sub_neg",  8'h83, 8'h05, 2'd0, 8'h88, 4'b0100);
        directed("shl_neg",  8'h85, 8'h02, 2'd2, 8'h94, 4'b0000);
        directed("bit_sign", 8'h80, 8'h07, 2'd3, 8'h00, 4'b0100);

        // Back-pressure: three back-to-back ops, only two fit.
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        in_a = 8'h5B; in_b = 8'h29; i_op = 2'd0; i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        in_a = 8'hB2; in_b = 8'h04; i_op = 2'd1;
        @(posedge i_clk);
        #1;
        in_a = 8'h66; in_b = 8'h03; i_op = 2'd3;
        @(negedge i_clk);
        check("stall_ready", o_ready, 1'b0);
        check("stall_valid", o_valid, 1'b1);
        check("stall_out", o_out, 8'h32);
        repeat (3) @(negedge i_clk);
        check("stall_hold_out", o_out, 8'h32);
        check("stall_hold_status", o_status, 4'b0000);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("drain1_out", o_out, 8'h32);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("drain2_valid", o_valid, 1'b1);
        check("drain2_out", o_out, 8'h04);
        check("drain2_status", o_status, 4'b1000);
        @(negedge i_clk);
        check("drain3_valid", o_valid, 1'b1);
        check("drain3_out", o_out, 8'h6E);
        @(negedge i_clk);
        check("drain_done", o_valid, 1'b0);

        // Reset during a stall discards everything in flight.
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        in_a = 8'hFF; in_b = 8'h01; i_op = 2'd0; i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        in_a = 8'h66; in_b = 8'h03; i_op = 2'd3;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check("pre_rst_valid", o_valid, 1'b1);
        #2;
        i_rst = 1'b1;
        q.delete();
        #1;
        check("async_rst_valid", o_valid, 1'b0);
        check("async_rst_out", o_out, 8'h00);
        check("async_rst_status", o_status, 4'b0000);
        check("async_rst_ready", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("post_rst_ready", o_ready, 1'b1);
        repeat (4) @(negedge i_clk);
        check("post_rst_no_stale", o_valid, 1'b0);

`ifdef EXE_UNIT_STICKY_EN
        // Sticky flags accumulate OVF and ERR, then clear.
        directed("sticky_sub", 8'hFF, 8'h01, 2'd0, 8'h80, 4'b1001);
        directed("sticky_shl", 8'h06, 8'h05, 2'd2, 8'h40, 4'b1001);
        directed("sticky_err", 8'hC1, 8'h81, 2'd2, 8'h00, 4'b0010);
        @(posedge i_clk);
        #1;
        check("sticky_acc", o_sticky, 4'b1011);
        i_sticky_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_sticky_clr = 1'b0;
        check("sticky_clr", o_sticky, 4'b0000);
`endif

        // Mixed traffic with random back-pressure, checked by the model.
        for (int n = 0; n < 300; n++) begin
            @(posedge i_clk);
            #1;
            in_a    = 8'($urandom);
            in_b    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            i_op    = 2'($urandom);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;
        check("final_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
